idex_stage: RTL and testbench

IDEX_STAGE -- requirements
Module: idex_stage

---
 rtl/idex_stage_pkg.sv | 43 ++++
 rtl/idex_stage_if.sv | 57 +++++
 rtl/idex_stage_fwd_mux.sv | 55 +++++
 rtl/idex_stage.sv | 157 +++++++++++++++
 tb/tb_idex_stage.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/idex_stage_pkg.sv
// -----------------------------------------------------------------------------
// idex_stage_pkg
// Shared definitions for the ID/EX pipeline register:
//   XLEN_DEF    - default operand/result width
//   REG_ZERO    - index of the hard-wired zero register x0
//   alu_op_e    - 4-bit ALU operation code
//   idex_ctrl_t - registered control payload carried from ID to EX
//   src_match   - producer-to-source register match rule
// -----------------------------------------------------------------------------
package idex_stage_pkg;

  localparam int XLEN_DEF = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_LUI  = 4'd10,
    ALU_PASS = 4'd11
  } alu_op_e;

  typedef struct packed {
    alu_op_e    alusel;
    logic [4:0] rd_addr;
    logic       rd_we;
    logic       is_load;
  } idex_ctrl_t;

  // x0 is never a forwarding target, whatever a producer claims to write.
  function automatic logic src_match(input logic [4:0] src, input logic [4:0] rd,
                                     input logic we);
    return (src != REG_ZERO) && we && (rd == src);
  endfunction

endpackage

// File: rtl/idex_stage_if.sv
// -----------------------------------------------------------------------------
// idex_id_if : decode -> ID/EX stage bundle (valid/ready + operands/control)
//   master = decoder (drives payload and in_valid, receives in_ready)
//   slave  = ID/EX stage
// idex_ex_if : ID/EX stage -> ALU bundle (valid/ready + registered operands)
//   master = ID/EX stage (drives payload and out_valid, receives out_ready)
//   slave  = ALU
// -----------------------------------------------------------------------------
interface idex_id_if #(parameter int XLEN = idex_stage_pkg::XLEN_DEF);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rs1_addr;
  logic [4:0]      in_rs2_addr;
  logic [4:0]      in_rd_addr;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] in_pc;
  logic            in_use_imm;
  logic            in_rd_we;
  logic            in_is_load;
  logic [3:0]      in_alusel;

  modport master (
    output in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rs1_data, in_rs2_data,
           in_imm, in_pc, in_use_imm, in_rd_we, in_is_load, in_alusel,
    input  in_ready
  );
  modport slave (
    input  in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rs1_data, in_rs2_data,
           in_imm, in_pc, in_use_imm, in_rd_we, in_is_load, in_alusel,
    output in_ready
  );
endinterface

interface idex_ex_if #(parameter int XLEN = idex_stage_pkg::XLEN_DEF);
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_rs1;
  logic [XLEN-1:0] out_rs2;
  logic [XLEN-1:0] out_pc;
  logic [3:0]      out_alusel;
  logic [4:0]      out_rd_addr;
  logic            out_rd_we;
  logic            out_is_load;

  modport master (
    output out_valid, out_rs1, out_rs2, out_pc, out_alusel, out_rd_addr, out_rd_we,
           out_is_load,
    input  out_ready
  );
  modport slave (
    input  out_valid, out_rs1, out_rs2, out_pc, out_alusel, out_rd_addr, out_rd_we,
           out_is_load,
    output out_ready
  );
endinterface

// File: rtl/idex_stage_fwd_mux.sv
// -----------------------------------------------------------------------------
// fwd_mux
// One source operand: detects EX/MEM and MEM/WB matches and selects the
// operand with priority EX/MEM > MEM/WB > register file. x0 always reads 0.
// Build option: IDEX_FORWARD_EN - when undefined the register-file value is
// always selected (hit flags are still reported for hazard detection).
// Ports:
//   src_addr_i/src_data_i           source index and register-file value
//   exm_rd_addr_i/_we_i/_result_i   EX/MEM producer
//   mwb_rd_addr_i/_we_i/_result_i   MEM/WB producer
//   data_o                          selected operand
//   exm_hit_o/mwb_hit_o             producer match flags
// -----------------------------------------------------------------------------
module fwd_mux
  import idex_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [4:0]      src_addr_i,
  input  logic [XLEN-1:0] src_data_i,
  input  logic [4:0]      exm_rd_addr_i,
  input  logic            exm_rd_we_i,
  input  logic [XLEN-1:0] exm_result_i,
  input  logic [4:0]      mwb_rd_addr_i,
  input  logic            mwb_rd_we_i,
  input  logic [XLEN-1:0] mwb_result_i,
  output logic [XLEN-1:0] data_o,
  output logic            exm_hit_o,
  output logic            mwb_hit_o
);

`ifdef IDEX_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  assign exm_hit_o = src_match(src_addr_i, exm_rd_addr_i, exm_rd_we_i);
  assign mwb_hit_o = src_match(src_addr_i, mwb_rd_addr_i, mwb_rd_we_i);

  // Priority operand select; the younger EX/MEM result wins over MEM/WB.
  always_comb begin
    data_o = src_data_i;
    if (src_addr_i == REG_ZERO) begin
      data_o = '0;
    end else if (FWD_EN && exm_hit_o) begin
      data_o = exm_result_i;
    end else if (FWD_EN && mwb_hit_o) begin
      data_o = mwb_result_i;
    end else begin
      data_o = src_data_i;
    end
  end

endmodule

// File: rtl/idex_stage.sv
// -----------------------------------------------------------------------------
// idex_stage
// Single-entry ID/EX pipeline register with operand forwarding, load-use
// hazard stall, flush and a saturating stall-cycle counter.
// Build option: IDEX_FORWARD_EN - forwarding enabled, stall only on load-use;
// undefined - no forwarding, stall on any in-flight producer match.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   id  (idex_id_if)      decode-side handshake, operands and control
//   ex  (idex_ex_if)      ALU-side handshake, registered operands and control
//   exm_*                 EX/MEM producer (rd index, we, is_load, result)
//   mwb_*                 MEM/WB producer (rd index, we, result)
//   flush                 squash held and incoming instruction
//   stall_cnt             saturating hazard stall cycle count
// -----------------------------------------------------------------------------
module idex_stage
  import idex_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  idex_id_if.slave         id,
  idex_ex_if.master        ex,
  input  logic [4:0]       exm_rd_addr,
  input  logic             exm_rd_we,
  input  logic             exm_is_load,
  input  logic [XLEN-1:0]  exm_result,
  input  logic [4:0]       mwb_rd_addr,
  input  logic             mwb_rd_we,
  input  logic [XLEN-1:0]  mwb_result,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

`ifdef IDEX_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [XLEN-1:0] rs1_fwd_s, rs2_fwd_s, rs2_sel_s;
  logic            rs1_exm_hit_s, rs1_mwb_hit_s, rs2_exm_hit_s, rs2_mwb_hit_s;
  logic            rs2_used_s, hazard_s, in_ready_s, capture_s;

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, pc_q, pc_d;
  idex_ctrl_t       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .src_addr_i   (id.in_rs1_addr),
    .src_data_i   (id.in_rs1_data),
    .exm_rd_addr_i(exm_rd_addr),
    .exm_rd_we_i  (exm_rd_we),
    .exm_result_i (exm_result),
    .mwb_rd_addr_i(mwb_rd_addr),
    .mwb_rd_we_i  (mwb_rd_we),
    .mwb_result_i (mwb_result),
    .data_o       (rs1_fwd_s),
    .exm_hit_o    (rs1_exm_hit_s),
    .mwb_hit_o    (rs1_mwb_hit_s)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .src_addr_i   (id.in_rs2_addr),
    .src_data_i   (id.in_rs2_data),
    .exm_rd_addr_i(exm_rd_addr),
    .exm_rd_we_i  (exm_rd_we),
    .exm_result_i (exm_result),
    .mwb_rd_addr_i(mwb_rd_addr),
    .mwb_rd_we_i  (mwb_rd_we),
    .mwb_result_i (mwb_result),
    .data_o       (rs2_fwd_s),
    .exm_hit_o    (rs2_exm_hit_s),
    .mwb_hit_o    (rs2_mwb_hit_s)
  );

  // rs2 is not a real source when the immediate replaces it.
  assign rs2_used_s = !id.in_use_imm;
  assign rs2_sel_s  = id.in_use_imm ? id.in_imm : rs2_fwd_s;

  // With forwarding only a load in EX/MEM cannot be bypassed; without it any
  // pending write to a used source must drain first.
  assign hazard_s = FWD_EN
    ? (exm_is_load && (rs1_exm_hit_s || (rs2_used_s && rs2_exm_hit_s)))
    : (rs1_exm_hit_s || rs1_mwb_hit_s ||
       (rs2_used_s && (rs2_exm_hit_s || rs2_mwb_hit_s)));

  assign in_ready_s = (!valid_q || ex.out_ready) && !hazard_s;
  assign capture_s  = id.in_valid && in_ready_s && !flush;
  assign id.in_ready = in_ready_s;

  // Next-state: flush beats capture, capture beats consume, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    pc_d    = pc_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture_s) begin
      valid_d = 1'b1;
      rs1_d   = rs1_fwd_s;
      rs2_d   = rs2_sel_s;
      pc_d    = id.in_pc;
      ctrl_d  = '{alusel:  alu_op_e'(id.in_alusel),
                  rd_addr: id.in_rd_addr,
                  rd_we:   id.in_rd_we,
                  is_load: id.in_is_load};
    end else if (valid_q && ex.out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (id.in_valid && hazard_s && !flush && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pipeline register and stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      pc_q    <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      pc_q    <= pc_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex.out_valid   = valid_q;
  assign ex.out_rs1     = rs1_q;
  assign ex.out_rs2     = rs2_q;
  assign ex.out_pc      = pc_q;
  assign ex.out_alusel  = ctrl_q.alusel;
  assign ex.out_rd_addr = ctrl_q.rd_addr;
  assign ex.out_rd_we   = ctrl_q.rd_we;
  assign ex.out_is_load = ctrl_q.is_load;
  assign stall_cnt      = cnt_q;

endmodule

// File: tb/tb_idex_stage.sv
// -----------------------------------------------------------------------------
// tb_idex_stage
// Self-checking bench for idex_stage: directed scenarios plus a randomized run
// against a cycle-level reference model. Built with or without
// IDEX_FORWARD_EN; expectations follow the same macro. The stall counter is
// narrowed to 4 bits so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_idex_stage;
  import idex_stage_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       exm_rd_addr, mwb_rd_addr;
  logic             exm_rd_we, exm_is_load, mwb_rd_we, flush;
  logic [XLEN-1:0]  exm_result, mwb_result;
  logic [CNT_W-1:0] stall_cnt;

  idex_id_if #(.XLEN(XLEN)) id_bus ();
  idex_ex_if #(.XLEN(XLEN)) ex_bus ();

  idex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id(id_bus), .ex(ex_bus),
    .exm_rd_addr(exm_rd_addr), .exm_rd_we(exm_rd_we), .exm_is_load(exm_is_load),
    .exm_result(exm_result), .mwb_rd_addr(mwb_rd_addr), .mwb_rd_we(mwb_rd_we),
    .mwb_result(mwb_result), .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state: the instruction the stage should be presenting.
  bit          m_valid;
  logic [31:0] m_rs1, m_rs2, m_pc;
  logic [3:0]  m_alusel;
  logic [4:0]  m_rd;
  bit          m_we, m_ld;
  int          m_cnt;

  function automatic bit writes(input logic [4:0] src, input logic [4:0] rd, input logic we);
    return (src != 5'd0) && (we === 1'b1) && (rd == src);
  endfunction

  function automatic logic [31:0] ref_operand(input logic [4:0] a, input logic [31:0] d);
    if (a == 5'd0) return 32'd0;
`ifdef IDEX_FORWARD_EN
    if (writes(a, exm_rd_addr, exm_rd_we)) return exm_result;
    if (writes(a, mwb_rd_addr, mwb_rd_we)) return mwb_result;
`endif
    return d;
  endfunction

  function automatic bit ref_hazard();
    logic [4:0] used[$];
    used.push_back(id_bus.in_rs1_addr);
    if (!id_bus.in_use_imm) used.push_back(id_bus.in_rs2_addr);
    foreach (used[k]) begin
`ifdef IDEX_FORWARD_EN
      if (exm_is_load && writes(used[k], exm_rd_addr, exm_rd_we)) return 1'b1;
`else
      if (writes(used[k], exm_rd_addr, exm_rd_we) || writes(used[k], mwb_rd_addr, mwb_rd_we))
        return 1'b1;
`endif
    end
    return 1'b0;
  endfunction

  function automatic bit ref_ready();
    return (!m_valid || ex_bus.out_ready) && !ref_hazard();
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    bit hz, cap;
    hz  = ref_hazard();
    cap = id_bus.in_valid && ref_ready() && !flush;
    if (id_bus.in_valid && hz && !flush && m_cnt < 15) m_cnt++;
    if (flush) m_valid = 1'b0;
    else if (cap) begin
      m_valid  = 1'b1;
      m_rs1    = ref_operand(id_bus.in_rs1_addr, id_bus.in_rs1_data);
      m_rs2    = id_bus.in_use_imm ? id_bus.in_imm
                                   : ref_operand(id_bus.in_rs2_addr, id_bus.in_rs2_data);
      m_pc     = id_bus.in_pc;
      m_alusel = id_bus.in_alusel;
      m_rd     = id_bus.in_rd_addr;
      m_we     = id_bus.in_rd_we;
      m_ld     = id_bus.in_is_load;
    end else if (m_valid && ex_bus.out_ready) m_valid = 1'b0;
  endtask

  task automatic idle();
    id_bus.in_valid = 1'b0;    id_bus.in_rs1_addr = 5'd0; id_bus.in_rs2_addr = 5'd0;
    id_bus.in_rd_addr = 5'd0;  id_bus.in_rs1_data = 32'd0; id_bus.in_rs2_data = 32'd0;
    id_bus.in_imm = 32'd0;     id_bus.in_pc = 32'd0;      id_bus.in_use_imm = 1'b0;
    id_bus.in_rd_we = 1'b0;    id_bus.in_is_load = 1'b0;  id_bus.in_alusel = 4'd0;
    exm_rd_addr = 5'd0; exm_rd_we = 1'b0; exm_is_load = 1'b0; exm_result = 32'd0;
    mwb_rd_addr = 5'd0; mwb_rd_we = 1'b0; mwb_result = 32'd0;
    flush = 1'b0; ex_bus.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_valid = 1'b0; m_rs1 = 32'd0; m_rs2 = 32'd0; m_pc = 32'd0;
    m_alusel = 4'd0; m_rd = 5'd0; m_we = 1'b0; m_ld = 1'b0; m_cnt = 0;
  endtask

  task automatic test_reset();
    logic [107:0] got;
    idle();
    rst = 1'b1;
    #1;
    got = {ex_bus.out_valid, ex_bus.out_rs1, ex_bus.out_rs2, ex_bus.out_pc, ex_bus.out_alusel,
           ex_bus.out_rd_addr, ex_bus.out_rd_we, ex_bus.out_is_load, 3'd0};
    checks++;
    if (got !== 108'd0 || stall_cnt !== 4'd0) begin
      failures++; $display("FAIL reset_values got=%h cnt=%0d expected all zero", got, stall_cnt);
    end
    do_reset();
    id_bus.in_valid = 1'b1; id_bus.in_pc = 32'h100; id_bus.in_rd_addr = 5'd9;
    @(posedge clk); #1;
    checks++;
    if (ex_bus.out_valid !== 1'b1 || ex_bus.out_pc !== 32'h100) begin
      failures++; $display("FAIL first_capture valid=%b pc=%h expected 1/100", ex_bus.out_valid, ex_bus.out_pc);
    end
    ex_bus.out_ready = 1'b0;
    id_bus.in_pc = 32'h200;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ex_bus.out_valid !== 1'b0 || ex_bus.out_pc !== 32'd0 || ex_bus.out_rd_addr !== 5'd0) begin
      failures++; $display("FAIL async_reset valid=%b pc=%h rd=%0d expected 0/0/0", ex_bus.out_valid, ex_bus.out_pc, ex_bus.out_rd_addr);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ex_bus.out_valid !== 1'b1 || ex_bus.out_pc !== 32'h200) begin
      failures++; $display("FAIL capture_after_reset valid=%b pc=%h expected 1/200", ex_bus.out_valid, ex_bus.out_pc);
    end
    idle();
  endtask

`ifdef IDEX_FORWARD_EN
  task automatic test_fwd_priority();
    do_reset();
    id_bus.in_valid = 1'b1; id_bus.in_rs1_addr = 5'd5; id_bus.in_rs1_data = 32'h55;
    id_bus.in_rs2_addr = 5'd5; id_bus.in_use_imm = 1'b1; id_bus.in_imm = 32'h99;
    exm_rd_addr = 5'd5; exm_rd_we = 1'b1; exm_result = 32'h11;
    mwb_rd_addr = 5'd5; mwb_rd_we = 1'b1; mwb_result = 32'h22;
    #1;
    checks++;
    if (id_bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL fwd_no_stall in_ready=%b expected 1", id_bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (ex_bus.out_valid !== 1'b1 || ex_bus.out_rs1 !== 32'h11 || ex_bus.out_rs2 !== 32'h99) begin
      failures++; $display("FAIL fwd_priority valid=%b rs1=%h rs2=%h expected 1/11/99", ex_bus.out_valid, ex_bus.out_rs1, ex_bus.out_rs2);
    end
    idle();
  endtask
`else
  task automatic test_no_fwd_stall();
    do_reset();
    id_bus.in_valid = 1'b1; id_bus.in_rs1_addr = 5'd7; id_bus.in_rs1_data = 32'h7070;
    id_bus.in_use_imm = 1'b1;
    mwb_rd_addr = 5'd7; mwb_rd_we = 1'b1; mwb_result = 32'h77;
    #1;
    checks++;
    if (id_bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL nofwd_ready in_ready=%b expected 0", id_bus.in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ex_bus.out_valid !== 1'b0 || stall_cnt !== 4'd2) begin
      failures++; $display("FAIL nofwd_stall valid=%b cnt=%0d expected 0/2", ex_bus.out_valid, stall_cnt);
    end
    mwb_rd_we = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ex_bus.out_valid !== 1'b1 || ex_bus.out_rs1 !== 32'h7070) begin
      failures++; $display("FAIL nofwd_operand valid=%b rs1=%h expected 1/7070", ex_bus.out_valid, ex_bus.out_rs1);
    end
    idle();
  endtask
`endif

  task automatic test_x0();
    do_reset();
    id_bus.in_valid = 1'b1; id_bus.in_rs1_addr = 5'd0; id_bus.in_rs1_data = 32'd0;
    id_bus.in_use_imm = 1'b1;
    exm_rd_addr = 5'd0; exm_rd_we = 1'b1; exm_result = 32'hFF; exm_is_load = 1'b1;
    mwb_rd_addr = 5'd0; mwb_rd_we = 1'b1; mwb_result = 32'hEE;
    @(posedge clk); #1;
    checks++;
    if (ex_bus.out_valid !== 1'b1 || ex_bus.out_rs1 !== 32'd0) begin
      failures++; $display("FAIL x0_not_forwarded valid=%b rs1=%h expected 1/0", ex_bus.out_valid, ex_bus.out_rs1);
    end
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    id_bus.in_valid = 1'b1; id_bus.in_rs1_addr = 5'd1; id_bus.in_rs1_data = 32'h1111;
    id_bus.in_rs2_addr = 5'd3; id_bus.in_rs2_data = 32'h3333; id_bus.in_use_imm = 1'b0;
    exm_rd_addr = 5'd3; exm_rd_we = 1'b1; exm_is_load = 1'b1; exm_result = 32'hAAAA0003;
    #1;
    checks++;
    if (id_bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL load_use_ready in_ready=%b expected 0", id_bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (ex_bus.out_valid !== 1'b0 || stall_cnt !== 4'd1) begin
      failures++; $display("FAIL load_use_stall valid=%b cnt=%0d expected 0/1", ex_bus.out_valid, stall_cnt);
    end
    exm_is_load = 1'b0;
`ifndef IDEX_FORWARD_EN
    exm_rd_we = 1'b0;
`endif
    #1;
    checks++;
    if (id_bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL load_use_release in_ready=%b expected 1", id_bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
`ifdef IDEX_FORWARD_EN
    if (ex_bus.out_valid !== 1'b1 || ex_bus.out_rs2 !== 32'hAAAA0003 || stall_cnt !== 4'd1) begin
      failures++; $display("FAIL load_use_capture valid=%b rs2=%h cnt=%0d expected 1/aaaa0003/1", ex_bus.out_valid, ex_bus.out_rs2, stall_cnt);
    end
`else
    if (ex_bus.out_valid !== 1'b1 || ex_bus.out_rs2 !== 32'h3333 || stall_cnt !== 4'd1) begin
      failures++; $display("FAIL load_use_capture valid=%b rs2=%h cnt=%0d expected 1/3333/1", ex_bus.out_valid, ex_bus.out_rs2, stall_cnt);
    end
`endif
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    ex_bus.out_ready = 1'b0;
    id_bus.in_valid = 1'b1; id_bus.in_rs1_addr = 5'd1; id_bus.in_rs1_data = 32'hA1;
    id_bus.in_pc = 32'hA0; id_bus.in_use_imm = 1'b1;
    @(posedge clk); #1;
    id_bus.in_rs1_data = 32'hB1; id_bus.in_pc = 32'hB0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (id_bus.in_ready !== 1'b0) begin
        failures++; $display("FAIL hold_ready cycle=%0d in_ready=%b expected 0", c, id_bus.in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (ex_bus.out_valid !== 1'b1 || ex_bus.out_rs1 !== 32'hA1 || ex_bus.out_pc !== 32'hA0) begin
        failures++; $display("FAIL hold_stable cycle=%0d valid=%b rs1=%h pc=%h expected 1/a1/a0", c, ex_bus.out_valid, ex_bus.out_rs1, ex_bus.out_pc);
      end
    end
    ex_bus.out_ready = 1'b1;
    #1;
    checks++;
    if (id_bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL consume_ready in_ready=%b expected 1", id_bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (ex_bus.out_valid !== 1'b1 || ex_bus.out_rs1 !== 32'hB1 || ex_bus.out_pc !== 32'hB0) begin
      failures++; $display("FAIL consume_capture valid=%b rs1=%h pc=%h expected 1/b1/b0", ex_bus.out_valid, ex_bus.out_rs1, ex_bus.out_pc);
    end
    id_bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ex_bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL drain valid=%b expected 0", ex_bus.out_valid);
    end
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    ex_bus.out_ready = 1'b0;
    id_bus.in_valid = 1'b1; id_bus.in_rs1_addr = 5'd2; id_bus.in_rs1_data = 32'hC1;
    id_bus.in_use_imm = 1'b1;
    @(posedge clk); #1;
    id_bus.in_rs1_data = 32'hD1; flush = 1'b1; ex_bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ex_bus.out_valid !== 1'b0 || ex_bus.out_rs1 !== 32'hC1) begin
      failures++; $display("FAIL flush valid=%b rs1=%h expected 0/c1", ex_bus.out_valid, ex_bus.out_rs1);
    end
    flush = 1'b0; id_bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ex_bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_stays valid=%b expected 0", ex_bus.out_valid);
    end
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    id_bus.in_valid = 1'b1; id_bus.in_rs1_addr = 5'd3; id_bus.in_use_imm = 1'b1;
    exm_rd_addr = 5'd3; exm_rd_we = 1'b1; exm_is_load = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 4'hF || ex_bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL stall_saturate cnt=%0d valid=%b expected 15/0", stall_cnt, ex_bus.out_valid);
    end
    idle();
  endtask

  task automatic rand_inputs();
    id_bus.in_valid    = ($urandom_range(0, 9) < 7);
    id_bus.in_rs1_addr = 5'($urandom_range(0, 7));
    id_bus.in_rs2_addr = 5'($urandom_range(0, 7));
    id_bus.in_rd_addr  = 5'($urandom_range(0, 31));
    id_bus.in_rs1_data = (id_bus.in_rs1_addr == 5'd0) ? 32'd0 : $urandom;
    id_bus.in_rs2_data = (id_bus.in_rs2_addr == 5'd0) ? 32'd0 : $urandom;
    id_bus.in_imm      = $urandom;
    id_bus.in_pc       = $urandom;
    id_bus.in_use_imm  = 1'($urandom_range(0, 1));
    id_bus.in_rd_we    = 1'($urandom_range(0, 1));
    id_bus.in_is_load  = ($urandom_range(0, 3) == 0);
    id_bus.in_alusel   = 4'($urandom_range(0, 15));
    exm_rd_addr = 5'($urandom_range(0, 7)); exm_rd_we = 1'($urandom_range(0, 1));
    exm_is_load = ($urandom_range(0, 2) == 0); exm_result = $urandom;
    mwb_rd_addr = 5'($urandom_range(0, 7)); mwb_rd_we = 1'($urandom_range(0, 1));
    mwb_result  = $urandom;
    flush = ($urandom_range(0, 11) == 0);
    ex_bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic test_random();
    logic [107:0] got, exp;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      #1;
      checks++;
      if (id_bus.in_ready !== ref_ready()) begin
        failures++; $display("FAIL rand_in_ready iter=%0d got=%b expected %b", i, id_bus.in_ready, ref_ready());
      end
      model_edge();
      @(posedge clk); #1;
      got = {ex_bus.out_valid, ex_bus.out_rs1, ex_bus.out_rs2, ex_bus.out_pc, ex_bus.out_alusel,
             ex_bus.out_rd_addr, ex_bus.out_rd_we, ex_bus.out_is_load, 3'd0};
      exp = {m_valid, m_rs1, m_rs2, m_pc, m_alusel, m_rd, m_we, m_ld, 3'd0};
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL rand_outputs iter=%0d got=%h expected %h", i, got, exp);
      end
      checks++;
      if (stall_cnt !== 4'(m_cnt)) begin
        failures++; $display("FAIL rand_stall_cnt iter=%0d got=%0d expected %0d", i, stall_cnt, m_cnt);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
`ifdef IDEX_FORWARD_EN
    test_fwd_priority();
`else
    test_no_fwd_stall();
`endif
    test_x0();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
